// File: rtl/chirp_dechirp.sv
// chirp_dechirp: regenerates a linear-chirp LO and mixes received I/Q with conj(LO).
// Build option DECHIRP_SAT_EN: clamp the 16-bit output instead of two's-complement wrap.
`timescale 1ns/1ps
module chirp_dechirp #(
    parameter  int unsigned LUT_AW = 10,
    parameter  int unsigned LO_W   = 16,
    localparam int unsigned PH_W   = 48,
    localparam int unsigned RATE_W = 32,
    localparam int unsigned D_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [PH_W-1:0]          DDS_freq,
    input  logic [PH_W-1:0]          DDS_delta_freq,
    input  logic [RATE_W-1:0]        DDS_delta_rate,
    input  logic signed [D_W-1:0]    din_I,
    input  logic signed [D_W-1:0]    din_Q,
    input  logic                     din_valid,
    output logic signed [D_W-1:0]    dout_I,
    output logic signed [D_W-1:0]    dout_Q,
    output logic                     dout_valid,
    output logic                     busy,
    output logic [RATE_W-1:0]        sample_cnt
);
    localparam int unsigned LAT  = 4;
    localparam int unsigned N    = 2 ** LUT_AW;
    localparam int unsigned MW   = D_W + LO_W;
    localparam int unsigned PW   = MW + 1;
    localparam real         PI   = 3.14159265358979323846;
    localparam real         AMP  = real'((2 ** (LO_W - 1)) - 1);
    localparam logic signed [PW-1:0] HALF  = PW'(2 ** (LO_W - 2));
    localparam logic signed [PW-1:0] MAX_V = PW'((2 ** (D_W - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

    typedef enum logic {IDLE, RUN} state_t;

    // Round-to-nearest, halves away from zero, for the LO table.
    function automatic logic signed [LO_W-1:0] round_lo(input real x);
        if (x >= 0.0) return LO_W'($rtoi(x + 0.5));
        return LO_W'(-$rtoi(0.5 - x));
    endfunction

    function automatic logic signed [D_W-1:0] narrow(input logic signed [PW-1:0] v);
`ifdef DECHIRP_SAT_EN
        if (v > MAX_V) return D_W'(MAX_V);
        if (v < MIN_V) return D_W'(MIN_V);
        return D_W'(v);
`else
        return D_W'(v);
`endif
    endfunction

    // Constant full-cycle cos/sin ROM.
    logic signed [LO_W-1:0] cos_rom [N];
    logic signed [LO_W-1:0] sin_rom [N];
    for (genvar k = 0; k < N; k++) begin : g_rom
        assign cos_rom[k] = round_lo(AMP * $cos(2.0 * PI * real'(k) / real'(N)));
        assign sin_rom[k] = round_lo(AMP * $sin(2.0 * PI * real'(k) / real'(N)));
    end

    state_t              state;
    logic                start_d;
    logic [PH_W-1:0]     phase;
    logic [PH_W-1:0]     inc;
    logic [PH_W-1:0]     delta_freq;
    logic [RATE_W-1:0]   delta_rate;
    logic [RATE_W-1:0]   rate_cnt;
    logic [LAT-2:0]      vld;

    logic                arm_c;
    logic                accept_c;
    logic                run_next_c;
    logic [LUT_AW-1:0]   addr_c;

    assign arm_c      = start & ~start_d;
    assign accept_c   = (state == RUN) & start & din_valid & ~arm_c;
    assign run_next_c = arm_c | ((state == RUN) & start);
    assign addr_c     = phase[PH_W-1 -: LUT_AW];

    // Control FSM, chirp accumulators and valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            phase      <= '0;
            inc        <= '0;
            delta_freq <= '0;
            delta_rate <= '0;
            rate_cnt   <= '0;
            sample_cnt <= '0;
            vld        <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            start_d    <= start;
            vld        <= {vld[LAT-3:0], accept_c};
            dout_valid <= vld[LAT-2];
            busy       <= run_next_c | accept_c | (|vld);
            if (arm_c) begin
                state      <= RUN;
                phase      <= '0;
                inc        <= DDS_freq;
                delta_freq <= DDS_delta_freq;
                delta_rate <= DDS_delta_rate;
                rate_cnt   <= '0;
                sample_cnt <= '0;
            end else if ((state == RUN) && !start) begin
                state <= IDLE;
            end else if (accept_c) begin
                phase      <= phase + inc;
                sample_cnt <= sample_cnt + RATE_W'(1);
                if (rate_cnt == delta_rate) begin
                    inc      <= inc + delta_freq;
                    rate_cnt <= '0;
                end else begin
                    rate_cnt <= rate_cnt + RATE_W'(1);
                end
            end
        end
    end

    logic signed [D_W-1:0]  x_i1, x_q1;
    logic signed [LO_W-1:0] c1, s1;
    logic signed [MW-1:0]   m_ic, m_qs, m_qc, m_is;
    logic signed [PW-1:0]   p_i, p_q;
    logic signed [PW-1:0]   rnd_i_c, rnd_q_c;

    // Datapath: LUT read, multiply, add/sub; stages load only with valid data.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            x_i1 <= din_I;
            x_q1 <= din_Q;
            c1   <= cos_rom[addr_c];
            s1   <= sin_rom[addr_c];
        end
        if (vld[0]) begin
            m_ic <= MW'(x_i1 * c1);
            m_qs <= MW'(x_q1 * s1);
            m_qc <= MW'(x_q1 * c1);
            m_is <= MW'(x_i1 * s1);
        end
        if (vld[1]) begin
            p_i <= PW'(m_ic) + PW'(m_qs);
            p_q <= PW'(m_qc) - PW'(m_is);
        end
    end

    // Round half up, drop the LO gain, then narrow to the output width.
    assign rnd_i_c = (p_i + HALF) >>> (LO_W - 1);
    assign rnd_q_c = (p_q + HALF) >>> (LO_W - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_I <= '0;
            dout_Q <= '0;
        end else if (vld[LAT-2]) begin
            dout_I <= narrow(rnd_i_c);
            dout_Q <= narrow(rnd_q_c);
        end
    end

endmodule

// File: tb/tb_chirp_dechirp.sv
// Directed bench for chirp_dechirp: scoreboard of hand-computed outputs plus latency checks.
`timescale 1ns/1ps
module tb_chirp_dechirp;
    localparam int unsigned LAT = 4;
    localparam logic [47:0] QTR = 48'h4000_0000_0000;
    localparam logic [47:0] OCT = 48'h2000_0000_0000;
`ifdef DECHIRP_SAT_EN
    localparam int T4_I = 32767;
`else
    localparam int T4_I = -19197;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [47:0]        DDS_freq;
    logic [47:0]        DDS_delta_freq;
    logic [31:0]        DDS_delta_rate;
    logic signed [15:0] din_I, din_Q;
    logic               din_valid;
    logic signed [15:0] dout_I, dout_Q;
    logic               dout_valid;
    logic               busy;
    logic [31:0]        sample_cnt;

    chirp_dechirp dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .DDS_freq       (DDS_freq),
        .DDS_delta_freq (DDS_delta_freq),
        .DDS_delta_rate (DDS_delta_rate),
        .din_I          (din_I),
        .din_Q          (din_Q),
        .din_valid      (din_valid),
        .dout_I         (dout_I),
        .dout_Q         (dout_Q),
        .dout_valid     (dout_valid),
        .busy           (busy),
        .sample_cnt     (sample_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string  tag;
        int     i;
        int     q;
        longint t;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    // Quarter-turn LO results for input (1000,0): 0, 90, 180, 270 degrees.
    int qi [4] = '{1000, 0, -1000, 0};
    int qq [4] = '{0, -1000, 0, 1000};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int i, input int q, input int ei, input int eq, input string tag);
        exp_t e;
        din_I     = 16'(i);
        din_Q     = 16'(q);
        din_valid = 1'b1;
        e.tag = tag; e.i = ei; e.q = eq; e.t = cyc;
        exp_q.push_back(e);
        tick(1);
        din_valid = 1'b0;
    endtask

    task automatic arm(input logic [47:0] f, input logic [47:0] d, input logic [31:0] r);
        start = 1'b0;
        tick(1);
        DDS_freq       = f;
        DDS_delta_freq = d;
        DDS_delta_rate = r;
        start          = 1'b1;
        tick(1);
    endtask

    // Output monitor: pops the scoreboard and checks data and 4-clock latency.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dout_valid) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_dout", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_I"}, longint'(dout_I), e.i);
                check({e.tag, "_Q"}, longint'(dout_Q), e.q);
                check({e.tag, "_lat"}, cyc - e.t, LAT);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int t3_ang [12] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 0, 2};
        rst = 1'b1; start = 1'b0; din_valid = 1'b0;
        din_I = '0; din_Q = '0;
        DDS_freq = '0; DDS_delta_freq = '0; DDS_delta_rate = '0;
        tick(3);
        check("rst_dout_I", longint'(dout_I), 0);
        check("rst_dout_Q", longint'(dout_Q), 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        rst = 1'b0;
        tick(1);

        // T1: zero frequency passes the input through unchanged.
        arm(48'd0, 48'd0, 32'd0);
        for (int k = 0; k < 8; k++) send(1000, -500, 1000, -500, "t1");
        tick(6);
        check("t1_sample_cnt", sample_cnt, 8);
        check("t1_busy_run", busy, 1);

        // T2: quarter-turn increment rotates the input by -90 degrees per sample.
        arm(QTR, 48'd0, 32'd0);
        for (int k = 0; k < 4; k++) send(1000, 0, qi[k], qq[k], "t2");
        tick(6);

        // T3: frequency steps every 4 samples, with idle gaps between samples.
        arm(48'd0, QTR, 32'd3);
        for (int k = 0; k < 12; k++) begin
            send(1000, 0, qi[t3_ang[k]], qq[t3_ang[k]], "t3");
            tick(3);
        end
        tick(4);
        check("t3_sample_cnt", sample_cnt, 12);

        // T4: 45-degree LO with full-scale input overflows the output range.
        arm(OCT, 48'd0, 32'd0);
        send(32767, 32767, 32766, 32766, "t4_s0");
        send(32767, 32767, T4_I, 0, "t4_s1");
        tick(6);

        // T5: dropping start stops acceptance; in-flight samples drain.
        arm(48'd0, 48'd0, 32'd0);
        for (int k = 0; k < 6; k++) send(100, 200, 100, 200, "t5");
        start = 1'b0;
        din_I = 16'sd7; din_Q = 16'sd7; din_valid = 1'b1;
        tick(1);
        snap = n_out;
        check("t5_busy_drain", busy, 1);
        tick(3);
        din_valid = 1'b0;
        tick(6);
        check("t5_drained", n_out - snap, 3);
        check("t5_busy_idle", busy, 0);
        check("t5_sample_cnt", sample_cnt, 6);

        // T6: synchronous reset mid-stream, then re-arm from phase 0.
        arm(QTR, 48'd0, 32'd0);
        for (int k = 0; k < 3; k++) send(1000, 0, qi[k], qq[k], "t6_pre");
        rst = 1'b1; start = 1'b0;
        din_I = 16'sd1000; din_Q = '0; din_valid = 1'b1;
        tick(1);
        check("t6_dout_valid", dout_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_sample_cnt", sample_cnt, 0);
        check("t6_dout_I", longint'(dout_I), 0);
        exp_q.delete();
        rst = 1'b0; din_valid = 1'b0;
        tick(1);
        arm(QTR, 48'd0, 32'd0);
        for (int k = 0; k < 4; k++) send(1000, 0, qi[k], qq[k], "t6");
        tick(6);
        check("t6_sample_cnt_rearm", sample_cnt, 4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
